// File: rtl/fifo_fwft_buffer_if.sv
// Purpose : write/read port bundle between the stream adapter and the FWFT FIFO storage.
// Latency : none, wires only.
// Backpressure: fifo_write_full stalls the writer; fifo_read_empty tells the reader nothing is presented.
//
// Ports:
//   fifo_write_full  - FIFO -> writer, no more words accepted
//   fifo_write_data  - writer -> FIFO, word to store
//   fifo_write_wren  - writer -> FIFO, write request
//   fifo_read_empty  - FIFO -> reader, no word presented
//   fifo_read_data   - FIFO -> reader, oldest word
//   fifo_read_rden   - reader -> FIFO, pop request
//   fifo_data_count  - FIFO -> both, words held (RAM + output register)
interface fifo_fwft_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  fifo_write_full;
    logic [DATA_WIDTH-1:0] fifo_write_data;
    logic                  fifo_write_wren;
    logic                  fifo_read_empty;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  fifo_read_rden;
    logic [ADDR_WIDTH:0]   fifo_data_count;

    // Producer/consumer side.
    modport master (
        input  fifo_write_full,
        output fifo_write_data,
        output fifo_write_wren,
        input  fifo_read_empty,
        input  fifo_read_data,
        output fifo_read_rden,
        input  fifo_data_count
    );

    // FIFO storage side.
    modport slave (
        output fifo_write_full,
        input  fifo_write_data,
        input  fifo_write_wren,
        output fifo_read_empty,
        output fifo_read_data,
        input  fifo_read_rden,
        output fifo_data_count
    );
endinterface

// File: rtl/fifo_fwft_buffer.sv
// Purpose : first-word-fall-through FIFO, 2^ADDR_WIDTH words in block RAM plus one output register.
// Latency : word accepted at edge k into an empty FIFO is presented after edge k+1.
// Backpressure: writes ignored while full, pops ignored while empty; read data held stable while rden=0.
//
// Ports:
//   aclk    - single clock, rising edge
//   aresetn - asynchronous active-low reset, synchronous release
//   fifo    - slave side of fifo_fwft_buffer_if (write port, read port, data count)
module fifo_fwft_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    fifo_fwft_buffer_if.slave    fifo
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t mem [DEPTH];

    ptr_t  wptr;
    ptr_t  rptr;
    cnt_t  mcount;      // words in RAM only
    cnt_t  count;       // words in RAM plus the output register
    word_t dout;
    logic  dout_valid;

    logic  full;
    logic  wr_ok;
    logic  pop;
    logic  prefetch;

    // Flags come from registered state only, so wren/rden never reach them combinationally.
    assign full     = (count == cnt_t'(DEPTH));
    assign wr_ok    = fifo.fifo_write_wren & ~full;
    assign pop      = fifo.fifo_read_rden & dout_valid;
    // Refill the output register whenever it is empty or being drained this edge.
    assign prefetch = (mcount != '0) & (~dout_valid | pop);

    assign fifo.fifo_write_full = full;
    assign fifo.fifo_read_empty = ~dout_valid;
    assign fifo.fifo_read_data  = dout;
    assign fifo.fifo_data_count = count;

    // RAM has no reset so it maps onto block RAM. A write strobed during reset lands at
    // mem[0] while wptr is held at 0; mcount stays 0, so that word is never read and is
    // overwritten by the first real write.
    always_ff @(posedge aclk) begin
        if (wr_ok) begin
            mem[wptr] <= fifo.fifo_write_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr       <= '0;
            rptr       <= '0;
            mcount     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ptr_t'(1);
            end

            // A prefetch reads an entry written at least one edge earlier (mcount != 0),
            // so there is no same-address read/write collision.
            if (prefetch) begin
                dout       <= mem[rptr];
                rptr       <= rptr + ptr_t'(1);
                dout_valid <= 1'b1;
            end else if (pop) begin
                // Popped with RAM empty: keep the last word in dout, just mark it stale.
                dout_valid <= 1'b0;
            end

            mcount <= mcount + cnt_t'(wr_ok) - cnt_t'(prefetch);
            count  <= count  + cnt_t'(wr_ok) - cnt_t'(pop);
        end
    end
endmodule

// File: doc/fifo_fwft_buffer.md
# fifo_fwft_buffer

Synchronous first-word-fall-through FIFO implementing the storage end of the FIFO_WRITE / FIFO_READ port pair driven by the AXI-Stream FIFO adapter. It accepts words on the write port, holds up to 2^ADDR_WIDTH words in inferred block RAM plus one output register, and presents the oldest word on the read port whenever it is not empty. It sits between the stream adapter and any producer/consumer sharing `aclk`, and replaces a vendor FIFO generator instance.

## Interface
- `DATA_WIDTH`, 32, width of every stored word (both ports)
- `ADDR_WIDTH`, 10, log2 of total capacity; DEPTH = 2^ADDR_WIDTH words
- `aclk` in 1: single clock, all logic on rising edge
- `aresetn` in 1: reset, asynchronous assert, active-low
- `fifo_write_full` out 1: no more words accepted
- `fifo_write_data` in DATA_WIDTH: word to store
- `fifo_write_wren` in 1: write request, accepted only when `fifo_write_full`=0
- `fifo_read_empty` out 1: no word presented on `fifo_read_data`
- `fifo_read_data` out DATA_WIDTH: oldest word, valid when `fifo_read_empty`=0
- `fifo_read_rden` in 1: pop request, honoured only when `fifo_read_empty`=0
- `fifo_data_count` out ADDR_WIDTH+1: total words held (RAM + output register)

## Operation
- Storage: RAM `mem[0..DEPTH-1]`, write pointer `wptr`, read pointer `rptr` (ADDR_WIDTH bits, wrap modulo DEPTH), RAM occupancy `mcount`, output register `dout` with flag `dout_valid`.
- Write accept: `wr_ok = fifo_write_wren & ~fifo_write_full`. On accept, `mem[wptr] <= fifo_write_data`, `wptr <= wptr+1`.
- Pop: `pop = fifo_read_rden & dout_valid`. `fifo_read_rden` while empty is ignored (adapter drives rden unconditionally); no state change, no underflow.
- Prefetch: when `mcount != 0` and (`~dout_valid` or `pop`), load `dout <= mem[rptr]`, `rptr <= rptr+1`, `dout_valid <= 1`. When `pop` and `mcount == 0`, `dout_valid <= 0`.
- `mcount` next = `mcount + wr_ok - prefetch`; `fifo_data_count` next = count + `wr_ok` - `pop`.
- `fifo_write_full` = (`fifo_data_count` == DEPTH); `fifo_read_empty` = `~dout_valid`. Both decoded from registers only, no combinational path from `wren`/`rden`.
- `fifo_write_wren` while full is ignored: no pointer move, no RAM write, count unchanged.
- Simultaneous accept and pop: count unchanged; ordering preserved.
- Full with simultaneous wren and rden: pop honoured, write rejected (full is registered state); full deasserts next cycle.
- `fifo_read_data` holds `dout` unchanged while `rden`=0 (stable under back-pressure); content while empty is don't-care but is the last popped word, never X after first write.

## Timing
- Reset (aresetn low, async): `wptr`=`rptr`=0, `mcount`=0, `fifo_data_count`=0, `dout_valid`=0, `dout`=0; outputs `fifo_write_full`=0, `fifo_read_empty`=1, `fifo_read_data`=0. Release is synchronous to next edge.
- Reset mid-operation discards all contents; writes/reads presented during reset are ignored.
- Write-to-read latency: word accepted at edge k into an empty FIFO appears with `fifo_read_empty`=0 after edge k+1 (RAM write k, prefetch k+1).
- `fifo_data_count` updates at the accepting edge, so count may read 1 while empty is still 1 for one cycle.
- Back-to-back pop: one word per cycle sustained while `mcount` > 0; new word visible after the popping edge.
- Full asserts after the edge that accepts word DEPTH; deasserts after the first pop edge.
- Throughput: 1 write and 1 read per cycle concurrently.

## Test plan
- Reset: hold aresetn low 5 cycles with wren=rden=1 -> full=0, empty=1, count=0, read_data=0; no state change.
- Ordering/latency (ADDR_WIDTH=4): write 0x01..0x05 on consecutive edges, rden=0 -> empty falls one cycle after first write, read_data=0x01 held; then rden=1 for 5 cycles -> 0x01..0x05 in order, empty=1 after 5th pop.
- Full/overflow: write 0x100..0x10F (16 words), then write 0xDEAD for 3 cycles -> full=1, count=16, 0xDEAD never read; drain returns 0x100..0x10F exactly.
- Underflow: empty FIFO, rden=1 for 4 cycles, then write 0xA5 -> count stays 0, then 0xA5 popped once, empty returns 1.
- Concurrent at full: full, assert wren (0xBEEF) and rden same cycle -> pop succeeds, 0xBEEF rejected, count=15, full=0 next cycle; wrap-around by streaming 100 words with random rden matches reference queue.
- Reset mid-stream: 7 words stored, pull aresetn low mid-cycle -> empty=1, count=0 immediately; after release new write 0x77 is first word read.
